// File: rtl/rf_access_master_if.sv
// rf_access_master_if: command, response and register-file signals of the access master
interface rf_access_master_if;
  logic cmd_valid;
  logic cmd_ready;
  logic cmd_write;
  logic [11:3] cmd_addr;
  logic [31:0] cmd_wdata;
  logic rsp_valid;
  logic rsp_ready;
  logic [31:0] rsp_rdata;
  logic rsp_invalid;
  logic rsp_timeout;
  logic [11:3] address;
  logic read_en;
  logic write_en;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic access_complete;
  logic invalid_address;
  modport master (
    input cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, read_data, access_complete, invalid_address,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_invalid, rsp_timeout, address, read_en, write_en, write_data
  );
  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, read_data, access_complete, invalid_address,
    input cmd_ready, rsp_valid, rsp_rdata, rsp_invalid, rsp_timeout, address, read_en, write_en, write_data
  );
endinterface

// File: rtl/rf_access_master.sv
// rf_access_master: single-outstanding register-file access master with completion timeout
module rf_access_master #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic clk,
  input logic res,
  rf_access_master_if.master bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t state_q, state_d;
  logic write_q, write_d;
  logic read_en_q, read_en_d;
  logic write_en_q, write_en_d;
  logic rsp_valid_q, rsp_valid_d;
  logic rsp_invalid_q, rsp_invalid_d;
  logic rsp_timeout_q, rsp_timeout_d;
  logic [15:0] cnt_q, cnt_d;
  logic [11:3] address_q, address_d;
  logic [31:0] write_data_q, write_data_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic accept, done, expire;
  assign bus.cmd_ready = state_q == IDLE;
  assign accept = bus.cmd_valid && state_q == IDLE;
  assign done = state_q == WAIT && bus.access_complete;
  assign expire = state_q == WAIT && !bus.access_complete && cnt_q == 16'(TIMEOUT_CYCLES - 1);
  assign bus.address = address_q;
  assign bus.write_data = write_data_q;
  assign bus.read_en = read_en_q;
  assign bus.write_en = write_en_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_invalid = rsp_invalid_q;
  assign bus.rsp_timeout = rsp_timeout_q;
  always_comb begin
    state_d = accept ? ISSUE
            : state_q == ISSUE ? WAIT
            : (done || expire) ? RESP
            : (state_q == RESP && bus.rsp_ready) ? IDLE
            : state_q;
    write_d = accept ? bus.cmd_write : write_q;
    address_d = accept ? bus.cmd_addr : address_q;
    write_data_d = accept ? bus.cmd_wdata : write_data_q;
    read_en_d = accept && !bus.cmd_write;
    write_en_d = accept && bus.cmd_write;
    cnt_d = state_q == WAIT ? cnt_q + 16'(!bus.access_complete) : 16'd0;
    rsp_valid_d = (done || expire) ? 1'b1 : (state_q == RESP && bus.rsp_ready) ? 1'b0 : rsp_valid_q;
    rsp_rdata_d = done ? ((!write_q && !bus.invalid_address) ? bus.read_data : 32'd0)
                : expire ? 32'd0 : rsp_rdata_q;
    rsp_invalid_d = done ? bus.invalid_address : expire ? 1'b0 : rsp_invalid_q;
    rsp_timeout_d = done ? 1'b0 : expire ? 1'b1 : rsp_timeout_q;
  end
  always_ff @(posedge clk) begin
    if (res) begin
      state_q <= IDLE;
      write_q <= 1'b0;
      read_en_q <= 1'b0;
      write_en_q <= 1'b0;
      cnt_q <= 16'd0;
      address_q <= '0;
      write_data_q <= 32'd0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'd0;
      rsp_invalid_q <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      write_q <= write_d;
      read_en_q <= read_en_d;
      write_en_q <= write_en_d;
      cnt_q <= cnt_d;
      address_q <= address_d;
      write_data_q <= write_data_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_invalid_q <= rsp_invalid_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end
endmodule

// File: doc/rf_access_master.md
RF_ACCESS_MASTER -- requirements
Module: rf_access_master

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255 (range 2..65535): WAIT cycles allowed before abort.
REQ-002 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-003 SHALL have port res  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port cmd_valid  input  1  command request present.
REQ-005 SHALL have port cmd_ready  output  1  master accepts command this cycle.
REQ-006 SHALL have port cmd_write  input  1  1=write, 0=read.
REQ-007 SHALL have port cmd_addr  input  [11:3]  register-file word address.
REQ-008 SHALL have port cmd_wdata  input  32  write data.
REQ-009 SHALL have port rsp_valid  output  1  response present.
REQ-010 SHALL have port rsp_ready  input  1  response consumed.
REQ-011 SHALL have port rsp_rdata  output  32  read data; 0 for writes, errors and timeouts.
REQ-012 SHALL have port rsp_invalid  output  1  register file reported invalid_address.
REQ-013 SHALL have port rsp_timeout  output  1  no access_complete within TIMEOUT_CYCLES.
REQ-014 SHALL have port address  output  [11:3]  address driven to the register file.
REQ-015 SHALL have port read_en  output  1  read strobe to the register file.
REQ-016 SHALL have port write_en  output  1  write strobe to the register file.
REQ-017 SHALL have port write_data  output  32  write data to the register file.
REQ-018 SHALL have port read_data  input  32  register-file read data.
REQ-019 SHALL have port access_complete  input  1  register-file completion.
REQ-020 SHALL have port invalid_address  input  1  register-file error, qualified by access_complete.

Function
REQ-021 SHALL implement FSM states IDLE, ISSUE, WAIT, RESP; all outputs registered except cmd_ready.
REQ-022 cmd_ready SHALL equal (state==IDLE); command accepted on cmd_valid && cmd_ready.
REQ-023 On acceptance in cycle N: latch cmd_addr into address, cmd_wdata into write_data, cmd_write internally; go ISSUE.
REQ-024 In ISSUE (cycle N+1): read_en or write_en high for exactly one cycle per command, never both; go WAIT.
REQ-025 address and write_data SHALL stay constant from N+1 until the state returns to IDLE.
REQ-026 access_complete SHALL be ignored in ISSUE and sampled only in WAIT.
REQ-027 WAIT: a 16-bit counter, cleared on WAIT entry, increments each WAIT cycle without access_complete.
REQ-028 WAIT with access_complete=1: rsp_rdata <= read_data (reads with invalid_address=0), else 0; rsp_invalid <= invalid_address; rsp_timeout <= 0; go RESP.
REQ-029 WAIT with counter == TIMEOUT_CYCLES-1 and access_complete=0: rsp_rdata <= 0, rsp_invalid <= 0, rsp_timeout <= 1; go RESP.
REQ-030 access_complete and timeout in the same cycle: completion wins.
REQ-031 RESP: rsp_valid=1, response fields stable; rsp_valid && rsp_ready -> IDLE next cycle.
REQ-032 rsp_ready while rsp_valid=0 SHALL have no effect.
REQ-033 Minimum command-to-command spacing 4 cycles (IDLE, ISSUE, WAIT, RESP); no pipelining, one outstanding access.
REQ-034 access_complete in IDLE, ISSUE or RESP (late completion after timeout) SHALL be ignored and cause no response.
REQ-035 cmd_* inputs outside the acceptance cycle SHALL be ignored.

Reset
REQ-036 While res=1 at a clock edge: state=IDLE, counter=0, read_en=0, write_en=0, address=0, write_data=0, rsp_valid=0, rsp_rdata=0, rsp_invalid=0, rsp_timeout=0.
REQ-037 Reset in any state SHALL abort the access with no response; cmd_ready=1 the first cycle after res deasserts.

Verification
REQ-038 Read: cmd addr 0x105, responder completes 2 cycles after read_en with 0xDEADBEEF -> one read_en pulse, address=0x105 held, rsp_rdata=0xDEADBEEF, invalid=0, timeout=0.
REQ-039 Write: addr 0x010, wdata 0x12345678 -> one write_en pulse, write_data=0x12345678, response rdata=0, both flags 0.
REQ-040 Invalid: completion with invalid_address=1, read_data=0xFFFFFFFF -> rsp_invalid=1, rsp_rdata=0.
REQ-041 Timeout: TIMEOUT_CYCLES=4, no completion -> rsp_valid exactly 4 WAIT cycles after read_en, rsp_timeout=1; completion injected later ignored.
REQ-042 Backpressure: rsp_ready low 5 cycles -> rsp_valid and fields stable, cmd_ready=0 throughout; next command accepted the cycle after handshake.
REQ-043 Reset mid-WAIT: res pulsed for 1 cycle -> all outputs at reset values, no rsp_valid, next command completes normally.
